// File: rtl/branch_ctrl.sv
// branch_ctrl: branch decode, PC-relative target generation and the
// start/init/run/halt program sequencer with a watchdog cycle limit.
module branch_ctrl #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES  = 16'd4000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] pc_addr,
  input  logic [8:0] instr,
  input  logic       cond_true,
  output logic       init,
  output logic       halt,
  output logic       isBranch,
  output logic [7:0] branchAddr,
  output logic       done,
  output logic       timeout,
  output logic [7:0] branch_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INIT   = 2'd1,
    S_RUN    = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  localparam logic [3:0]  INIT_LOAD = 4'(INIT_CYCLES);
  localparam logic [15:0] CYC_LAST  = MAX_CYCLES - 16'd1;

  state_e      state_q, state_d;
  logic [3:0]  init_cnt_q, init_cnt_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic        timeout_q, timeout_d;

  logic        br_taken;
  logic        halt_instr;

  // Target is always presented; consumers only use it when isBranch is high.
  assign branchAddr   = pc_addr + {{4{instr[3]}}, instr[3:0]};
  assign timeout      = timeout_q;
  assign branch_count = bcnt_q;

  // Decode the branch group: taken condition and HALT detection.
  always_comb begin
    br_taken   = 1'b0;
    halt_instr = 1'b0;
    if (instr[8:6] == 3'b111) begin
      case (instr[5:4])
        2'b00:   br_taken = cond_true;
        2'b01:   br_taken = ~cond_true;
        2'b10:   br_taken = 1'b1;
        2'b11:   halt_instr = (instr[3:0] == 4'hF);
        default: br_taken = 1'b0;
      endcase
    end else begin
      br_taken   = 1'b0;
      halt_instr = 1'b0;
    end
  end

  // Sequencer next-state and PC control outputs.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    bcnt_d     = bcnt_q;
    timeout_d  = timeout_q;
    init       = 1'b0;
    halt       = 1'b0;
    isBranch   = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        halt = 1'b1;
        if (start) begin
          state_d    = S_INIT;
          init_cnt_d = INIT_LOAD;
          cyc_cnt_d  = 16'd0;
          bcnt_d     = 8'd0;
          timeout_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        init = 1'b1;
        if (init_cnt_q <= 4'd1) begin
          state_d = S_RUN;
        end else begin
          init_cnt_d = init_cnt_q - 4'd1;
        end
      end
      S_RUN: begin
        cyc_cnt_d = cyc_cnt_q + 16'd1;
        if (halt_instr) begin
          // HALT beats a simultaneous watchdog expiry.
          halt      = 1'b1;
          state_d   = S_HALTED;
          timeout_d = 1'b0;
        end else begin
          isBranch = br_taken;
          if (br_taken && (bcnt_q != 8'hFF)) begin
            bcnt_d = bcnt_q + 8'd1;
          end else begin
            bcnt_d = bcnt_q;
          end
          if (cyc_cnt_q == CYC_LAST) begin
            state_d   = S_HALTED;
            timeout_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_HALTED: begin
        halt = 1'b1;
        done = 1'b1;
        if (start) begin
          state_d    = S_INIT;
          init_cnt_d = INIT_LOAD;
          cyc_cnt_d  = 16'd0;
          bcnt_d     = 8'd0;
          timeout_d  = 1'b0;
        end else begin
          state_d = S_HALTED;
        end
      end
      default: begin
        halt    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      init_cnt_q <= 4'd0;
      cyc_cnt_q  <= 16'd0;
      bcnt_q     <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      bcnt_q     <= bcnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule
